// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency
// instruction memory and presents {PC+step, instruction} to the IF/ID register.
// Latency: at least 2 cycles per instruction (FETCH then READY). Backpressure:
// freeze holds READY. A branch redirect overrides freeze.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   freeze              hazard stall; holds the presented instruction/PC in READY
//   branch_taken/addr   single-cycle redirect from EX
//   imem_req/addr       request outstanding and its address (stable until valid)
//   imem_valid/rdata    one-cycle response strobe and instruction word
//   if_valid            pc_out/instruction carry a real fetch (zeros otherwise)
//   pc_out              fetched address + PC_STEP
//   instruction         fetched instruction word
module if_fetch_stage #(
  parameter int                     WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0]    RESET_PC = '0,
  parameter int                     PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_addr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                if_valid,
  output logic [WORD_LEN-1:0] pc_out,
  output logic [WORD_LEN-1:0] instruction
);

  // FETCH: request outstanding, result wanted.
  // READY: instruction buffered and presented downstream.
  // DRAIN: a redirect arrived mid-request; wait for the stale response
  //        before issuing the new address, so imem_addr never changes
  //        under an outstanding request.
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] READY = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(PC_STEP);

  logic [1:0]          state;
  logic [WORD_LEN-1:0] pc;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] inst_q;
  logic [WORD_LEN-1:0] next_seq;

  // Wraps naturally modulo 2^WORD_LEN.
  assign next_seq = addr_q + STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      inst_q <= '0;
      state  <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            if (branch_taken) begin
              // Response belongs to the wrong path; restart at the target
              // next cycle (addr_q changes only now that the request ended).
              pc     <= branch_addr;
              addr_q <= branch_addr;
            end else begin
              inst_q <= imem_rdata;
              state  <= READY;
            end
          end else if (branch_taken) begin
            // Request still in flight: remember the target, keep imem_addr.
            pc    <= branch_addr;
            state <= DRAIN;
          end
        end
        READY: begin
          if (branch_taken) begin
            pc     <= branch_addr;
            addr_q <= branch_addr;
            state  <= FETCH;
          end else if (!freeze) begin
            pc     <= next_seq;
            addr_q <= next_seq;
            state  <= FETCH;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            pc <= branch_addr;
          end
          if (imem_valid) begin
            // A redirect in the same cycle as the stale response wins.
            addr_q <= branch_taken ? branch_addr : pc;
            state  <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = addr_q;
  assign if_valid    = (state == READY);
  assign pc_out      = (state == READY) ? next_seq : '0;
  assign instruction = (state == READY) ? inst_q : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios followed by randomized
// redirect/freeze/reset traffic against a variable-latency memory model and
// a flag-based reference model of the fetch stage.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction;

  if_fetch_stage #(
    .WORD_LEN (32),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .pc_out       (pc_out),
    .instruction  (instruction)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory model: a request starts the first cycle req is seen while idle,
  // and is answered 'lat' cycles later.
  bit          mbusy = 1'b0;
  logic [31:0] maddr = '0;
  int          mcnt  = 0;
  int          lat   = 1;
  bit          spurious = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Reference model: holding an instruction, draining a stale response,
  // or plainly fetching.
  bit          r_have  = 1'b0;
  bit          r_stale = 1'b0;
  logic [31:0] r_pc    = '0;
  logic [31:0] r_addr  = '0;
  logic [31:0] r_inst  = '0;

  task automatic step(input bit r, input bit fz, input bit br, input logic [31:0] ba);
    bit          v;
    logic [31:0] rd;
    logic [31:0] npc;
    v  = 1'b0;
    rd = $urandom;
    if (mbusy) begin
      chk("addr_hold", imem_addr, maddr);
      mcnt--;
      if (mcnt == 0) begin
        v     = 1'b1;
        rd    = mem_word(maddr);
        mbusy = 1'b0;
      end
    end else if (imem_req === 1'b1) begin
      mbusy = 1'b1;
      maddr = imem_addr;
      mcnt  = lat;
    end else if (spurious && $urandom_range(0, 3) == 0) begin
      v = 1'b1;  // no request outstanding: must be ignored
    end

    rst = r; freeze = fz; branch_taken = br; branch_addr = ba;
    imem_valid = v; imem_rdata = rd;

    if (r) begin
      r_have = 0; r_stale = 0; r_pc = '0; r_addr = '0; r_inst = '0;
      mbusy  = 1'b0;
    end else if (r_have) begin
      if (br) begin
        r_pc = ba; r_addr = ba; r_have = 0;
      end else if (!fz) begin
        r_addr = r_addr + 32'd4; r_pc = r_addr; r_have = 0;
      end
    end else if (r_stale) begin
      npc  = br ? ba : r_pc;
      r_pc = npc;
      if (v) begin
        r_addr = npc; r_stale = 0;
      end
    end else begin
      if (v && !br) begin
        r_inst = rd; r_have = 1;
      end else if (br) begin
        r_pc = ba;
        if (v) r_addr = ba;
        else   r_stale = 1;
      end
    end

    @(posedge clk);
    #1;
    chk("imem_req",    32'(imem_req), 32'(!r_have));
    chk("imem_addr",   imem_addr, r_addr);
    chk("if_valid",    32'(if_valid), 32'(r_have));
    chk("pc_out",      pc_out, r_have ? r_addr + 32'd4 : 32'h0);
    chk("instruction", instruction, r_have ? r_inst : 32'h0);
  endtask

  task automatic run_until_ready(input string tag);
    int n;
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      step(0, 0, 0, 32'h0);
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(if_valid), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, first fetch at 0 with 1-cycle memory
    lat = 1;
    step(1, 0, 0, 32'h0);
    chk("rst_req",   32'(imem_req), 32'h1);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc",    pc_out, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("t1_valid", 32'(if_valid), 32'h1);
    chk("t1_pc",    pc_out, 32'h4);
    chk("t1_inst",  instruction, 32'h1111_1111);
    step(0, 0, 0, 32'h0);
    chk("t1_next_req",  32'(imem_req), 32'h1);
    chk("t1_next_addr", imem_addr, 32'h4);

    // 2: freeze for 3 cycles while READY at 8
    run_until_ready("t2a");
    step(0, 0, 0, 32'h0);
    run_until_ready("t2b");
    chk("t2_pc0", pc_out, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0);
      chk("t2_frz_req",  32'(imem_req), 32'h0);
      chk("t2_frz_pc",   pc_out, 32'hC);
      chk("t2_frz_inst", instruction, mem_word(32'h8));
    end
    step(0, 0, 0, 32'h0);
    chk("t2_rel_req",  32'(imem_req), 32'h1);
    chk("t2_rel_addr", imem_addr, 32'hC);

    // 3: redirect to 0x40 while a 3-cycle request to 0x10 is in flight
    run_until_ready("t3a");
    step(0, 0, 1, 32'h10);
    lat = 3;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h40);
    chk("t3_drain_addr",  imem_addr, 32'h10);
    chk("t3_drain_valid", 32'(if_valid), 32'h0);
    step(0, 0, 0, 32'h0);
    chk("t3_disc_valid", 32'(if_valid), 32'h0);
    chk("t3_new_addr",   imem_addr, 32'h40);
    lat = 1;
    run_until_ready("t3b");
    chk("t3_pc", pc_out, 32'h44);

    // 4: branch together with freeze in READY
    step(0, 1, 1, 32'h80);
    chk("t4_addr",  imem_addr, 32'h80);
    chk("t4_valid", 32'(if_valid), 32'h0);
    chk("t4_inst",  instruction, 32'h0);

    // 5: two redirects during DRAIN, only the last one is fetched
    lat = 4;
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h20);
    step(0, 0, 1, 32'h30);
    chk("t5_drain_addr", imem_addr, 32'h80);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("t5_addr", imem_addr, 32'h30);
    lat = 1;
    run_until_ready("t5");
    chk("t5_pc",   pc_out, 32'h34);
    chk("t5_inst", instruction, mem_word(32'h30));

    // 6: reset mid-fetch at 0x100, then PC wrap
    step(0, 0, 1, 32'h100);
    lat = 3;
    step(0, 0, 0, 32'h0);
    chk("t6_pre_addr", imem_addr, 32'h100);
    step(1, 0, 0, 32'h0);
    chk("t6_addr",  imem_addr, 32'h0);
    chk("t6_valid", 32'(if_valid), 32'h0);
    chk("t6_pc",    pc_out, 32'h0);
    chk("t6_inst",  instruction, 32'h0);
    lat = 1;
    run_until_ready("t6a");
    chk("t6_inst0", instruction, 32'h1111_1111);
    step(0, 0, 1, 32'hFFFF_FFFC);
    run_until_ready("t6b");
    chk("wrap_pc", pc_out, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Randomized traffic
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit          r, fz, br;
      logic [31:0] ba;
      lat = $urandom_range(1, 4);
      r   = ($urandom_range(0, 63) == 0);
      fz  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 5) == 0);
      ba  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      step(r, fz, br, ba);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
